sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the successor to the fixed 32-bit FIFO used between the entropy-coding stages and the bitstream packer.
- Generalised data width and depth.
- Adds full, almost-full and almost-empty flags, an occupancy count, sticky overflow/underflow error flags, and simultaneous read/write when full.
- Keeps the existing request/valid read protocol: read_req in, registered read_data plus one-cycle rdata_valid out.

---
 rtl/sync_fifo_param.sv | 98 +++++++++
 tb/tb_sync_fifo_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with request/valid read port, occupancy flags
// and sticky overflow/underflow indicators. Storage is intentionally not reset.
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     read_req,
  input  logic                     clear_err,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rdata_valid,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [CW-1:0]     next_count;

  // A full FIFO may still take a write when a read frees a slot in the same edge.
  always_comb begin
    rd_acc = read_req & ~fifo_empty;
    wr_acc = write_enable & (~fifo_full | rd_acc);
    next_count = fill_count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = fill_count + CW'(1);
      2'b01:   next_count = fill_count - CW'(1);
      default: next_count = fill_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      read_data    <= '0;
      rdata_valid  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      rdata_valid  <= rd_acc;
      fill_count   <= next_count;
      // Flags come from the next count so they line up with fill_count.
      fifo_empty   <= (next_count == '0);
      fifo_full    <= (next_count == DEPTH_C);
      almost_full  <= (next_count >= AF_C);
      almost_empty <= (next_count <= AE_C);
      if (write_enable && !wr_acc) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (read_req && fifo_empty) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int AE_LEVEL = 1;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic              read_req;
  logic              clear_err;
  logic [DATA_W-1:0] read_data;
  logic              rdata_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     fill_count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_rdata;
  logic              model_valid;
  logic              model_ovf;
  logic              model_unf;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_data(write_data),
    .read_req(read_req), .clear_err(clear_err), .read_data(read_data),
    .rdata_valid(rdata_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [DATA_W-1:0] observed,
                          input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    int sz;
    sz = model_q.size();
    checkVal("read_data",    read_data,            model_rdata);
    checkVal("rdata_valid",  32'(rdata_valid),     32'(model_valid));
    checkVal("fifo_empty",   32'(fifo_empty),      32'(sz == 0));
    checkVal("fifo_full",    32'(fifo_full),       32'(sz == DEPTH));
    checkVal("almost_full",  32'(almost_full),     32'(sz >= AF_LEVEL));
    checkVal("almost_empty", 32'(almost_empty),    32'(sz <= AE_LEVEL));
    checkVal("fill_count",   32'(fill_count),      32'(sz));
    checkVal("overflow",     32'(overflow),        32'(model_ovf));
    checkVal("underflow",    32'(underflow),       32'(model_unf));
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input logic we, input logic [DATA_W-1:0] wd,
                               input logic rr, input logic ce, input logic rs);
    int  pre_size;
    logic do_rd;
    logic do_wr;
    write_enable = we;
    write_data   = wd;
    read_req     = rr;
    clear_err    = ce;
    rst          = rs;
    @(posedge clk);
    pre_size = model_q.size();
    if (rs) begin
      model_q.delete();
      model_rdata = '0;
      model_valid = 1'b0;
      model_ovf   = 1'b0;
      model_unf   = 1'b0;
    end else begin
      do_rd = rr && (pre_size > 0);
      do_wr = we && ((pre_size < DEPTH) || do_rd);
      model_valid = do_rd;
      if (do_rd) model_rdata = model_q.pop_front();
      if (do_wr) model_q.push_back(wd);
      if (we && !do_wr) model_ovf = 1'b1;
      else if (ce)      model_ovf = 1'b0;
      if (rr && pre_size == 0) model_unf = 1'b1;
      else if (ce)             model_unf = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] pattern [4];
    model_rdata = '0;
    model_valid = 1'b0;
    model_ovf   = 1'b0;
    model_unf   = 1'b0;

    // Reset state
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 1);
    checkVal("reset_empty", 32'(fifo_empty), 32'd1);

    // Fill and drain in order
    pattern[0] = 32'd10; pattern[1] = 32'd20; pattern[2] = 32'd30; pattern[3] = 32'd40;
    for (int i = 0; i < 4; i++) applyStimulus(1, pattern[i], 0, 0, 0);
    checkVal("t1_full", 32'(fifo_full), 32'd1);
    checkVal("t1_af",   32'(almost_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 0, 0);
      checkVal("t1_rd", read_data, pattern[i]);
      applyStimulus(0, '0, 0, 0, 0);
      checkVal("t1_pulse", 32'(rdata_valid), 32'd0);
    end
    checkVal("t1_ae", 32'(almost_empty), 32'd1);

    // Simultaneous read/write while full, then drain across the wrap
    for (int i = 1; i <= 4; i++) applyStimulus(1, DATA_W'(i), 0, 0, 0);
    applyStimulus(1, 32'd5, 1, 0, 0);
    checkVal("t2_rd1", read_data, 32'd1);
    checkVal("t2_cnt", 32'(fill_count), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(0, '0, 1, 0, 0);
      checkVal("t2_rd", read_data, DATA_W'(i));
    end

    // Overflow on full, clear, contents intact
    for (int i = 11; i <= 14; i++) applyStimulus(1, DATA_W'(i), 0, 0, 0);
    applyStimulus(1, 32'd99, 0, 0, 0);
    checkVal("t3_ovf", 32'(overflow), 32'd1);
    applyStimulus(0, '0, 0, 1, 0);
    checkVal("t3_clr", 32'(overflow), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      applyStimulus(0, '0, 1, 0, 0);
      checkVal("t3_rd", read_data, DATA_W'(i));
    end

    // Underflow, then write+read on empty accepts only the write
    applyStimulus(0, '0, 1, 0, 0);
    checkVal("t4_unf", 32'(underflow), 32'd1);
    checkVal("t4_rd_hold", read_data, 32'd14);
    applyStimulus(1, 32'd7, 1, 0, 0);
    checkVal("t4_cnt", 32'(fill_count), 32'd1);
    applyStimulus(0, '0, 1, 1, 0);
    checkVal("t4_rd7", read_data, 32'd7);

    // Reset mid-stream with a pending read
    for (int i = 1; i <= 3; i++) applyStimulus(1, 32'hA5A5_0000 + DATA_W'(i), 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 1);
    checkVal("t5_novalid", 32'(rdata_valid), 32'd0);
    applyStimulus(1, 32'h11, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkVal("t5_rd11", read_data, 32'h11);

    // Streaming with two words preloaded
    applyStimulus(1, 32'h0000_00C1, 0, 0, 0);
    applyStimulus(1, 32'h0000_00C2, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      v = DATA_W'($urandom_range(0, 255));
      applyStimulus(1, v, 1, 0, 0);
      checkVal("t6_cnt", 32'(fill_count), 32'd2);
      checkVal("t6_valid", 32'(rdata_valid), 32'd1);
    end

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
